gpio_bus_arbiter: RTL and testbench

//  Shares the single-port GPIO register interface (addr/data_in/rd_en/wr_en/data_out) between NUM_REQ masters.

---
 rtl/gpio_bus_arbiter_if.sv | 31 +++
 rtl/gpio_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_gpio_bus_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/gpio_bus_arbiter_if.sv
// Requester-side and GPIO-side signal bundle for gpio_bus_arbiter.
// The arbiter uses the slave modport; the masters and the GPIO stub use master.
interface gpio_bus_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 2
);
  logic [NUM_REQ-1:0]    req;
  logic [NUM_REQ-1:0]    req_we;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0]    gnt;
  logic [NUM_REQ-1:0]    rvalid;
  logic [DW-1:0]         rdata;
  logic                  busy;
  logic [AW-1:0]         gpio_addr;
  logic [DW-1:0]         gpio_data_in;
  logic                  gpio_rd_en;
  logic                  gpio_wr_en;
  logic [DW-1:0]         gpio_data_out;

  modport slave (
    input  req, req_we, req_addr, req_wdata, gpio_data_out,
    output gnt, rvalid, rdata, busy, gpio_addr, gpio_data_in, gpio_rd_en, gpio_wr_en
  );

  modport master (
    output req, req_we, req_addr, req_wdata, gpio_data_out,
    input  gnt, rvalid, rdata, busy, gpio_addr, gpio_data_in, gpio_rd_en, gpio_wr_en
  );
endinterface

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter sharing one GPIO register port among NUM_REQ masters.
// One transaction in flight; reads wait out the GPIO's one-cycle registered read.
module gpio_bus_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 2
) (
  input logic               clk,
  input logic               reset,
  gpio_bus_arbiter_if.slave bus
);

  localparam int unsigned IW = (NUM_REQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_d;
  logic [IW-1:0]       r_rr_ptr;
  logic [IW-1:0]       r_win_id;
  logic                r_we;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_rvalid;
  logic [DW-1:0]       r_rdata;
  logic                r_busy;
  logic [AW-1:0]       r_gpio_addr;
  logic [DW-1:0]       r_gpio_data_in;
  logic                r_gpio_rd_en;
  logic                r_gpio_wr_en;

  logic                w_req_any;
  logic [IW-1:0]       w_win_id;
  logic [IW-1:0]       w_idx;
  logic                w_sel_we;
  logic [AW-1:0]       w_sel_addr;
  logic [DW-1:0]       w_sel_wdata;
  logic                w_accept;
  logic [NUM_REQ-1:0]  w_gnt_d;
  logic [NUM_REQ-1:0]  w_rvalid_d;
  logic                w_rd_en_d;
  logic                w_wr_en_d;
  logic [IW-1:0]       w_rr_next;

  // Winner search: first asserted req starting at the rr pointer, wrapping.
  always_comb begin
    w_req_any = 1'b0;
    w_win_id  = '0;
    w_idx     = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % int'(NUM_REQ));
      if (!w_req_any && bus.req[w_idx]) begin
        w_req_any = 1'b1;
        w_win_id  = w_idx;
      end
    end
  end

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int k = 0; k < int'(NUM_REQ); k++) begin
      if (w_win_id == IW'(k)) begin
        w_sel_we    = bus.req_we[k];
        w_sel_addr  = bus.req_addr[k*int'(AW) +: AW];
        w_sel_wdata = bus.req_wdata[k*int'(DW) +: DW];
      end
    end
  end

  assign w_accept  = (r_state == IDLE) && w_req_any;
  assign w_rr_next = (r_win_id == IW'(NUM_REQ - 1)) ? '0 : r_win_id + IW'(1);

  // Next state and next values of the registered outputs.
  always_comb begin
    w_state_d  = r_state;
    w_gnt_d    = '0;
    w_rvalid_d = '0;
    w_rd_en_d  = 1'b0;
    w_wr_en_d  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_any) begin
          w_state_d = ISSUE;
          w_gnt_d   = NUM_REQ'(1) << w_win_id;
          w_wr_en_d = w_sel_we;
          w_rd_en_d = ~w_sel_we;
        end
      end
      ISSUE:   w_state_d = r_we ? IDLE : RDWAIT;
      RDWAIT: begin
        w_state_d  = RESP;
        w_rvalid_d = NUM_REQ'(1) << r_win_id;
      end
      RESP:    w_state_d = IDLE;
      default: w_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_win_id       <= '0;
      r_we           <= 1'b0;
      r_gnt          <= '0;
      r_rvalid       <= '0;
      r_rdata        <= '0;
      r_busy         <= 1'b0;
      r_gpio_addr    <= '0;
      r_gpio_data_in <= '0;
      r_gpio_rd_en   <= 1'b0;
      r_gpio_wr_en   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_gnt        <= w_gnt_d;
      r_rvalid     <= w_rvalid_d;
      r_busy       <= (w_state_d != IDLE);
      r_gpio_rd_en <= w_rd_en_d;
      r_gpio_wr_en <= w_wr_en_d;
      if (w_accept) begin
        r_win_id       <= w_win_id;
        r_we           <= w_sel_we;
        r_gpio_addr    <= w_sel_addr;
        r_gpio_data_in <= w_sel_wdata;
      end
      if (r_state == ISSUE) begin
        r_rr_ptr <= w_rr_next;
      end
      // GPIO data_out is valid the cycle after rd_en.
      if (r_state == RDWAIT) begin
        r_rdata <= bus.gpio_data_out;
      end
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.rvalid       = r_rvalid;
  assign bus.rdata        = r_rdata;
  assign bus.busy         = r_busy;
  assign bus.gpio_addr    = r_gpio_addr;
  assign bus.gpio_data_in = r_gpio_data_in;
  assign bus.gpio_rd_en   = r_gpio_rd_en;
  assign bus.gpio_wr_en   = r_gpio_wr_en;

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with two masters and a registered-read GPIO stub.
module tb_gpio_bus_arbiter;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned DW      = 32;
  localparam int unsigned AW      = 2;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [DW-1:0] gpio_regs [4];

  gpio_bus_arbiter_if #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) bus ();

  gpio_bus_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GPIO stub: register 0 preset to 5, data_out registered one cycle after rd_en.
  always @(posedge clk) begin
    if (reset) begin
      gpio_regs[0]      <= 32'h5;
      gpio_regs[1]      <= 32'h0;
      gpio_regs[2]      <= 32'h0;
      gpio_regs[3]      <= 32'h0;
      bus.gpio_data_out <= 32'h0;
    end else begin
      if (bus.gpio_wr_en) gpio_regs[bus.gpio_addr] <= bus.gpio_data_in;
      if (bus.gpio_rd_en) bus.gpio_data_out <= gpio_regs[bus.gpio_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"},    32'(bus.gnt),          32'h0);
    chk({tag, "_rvalid"}, 32'(bus.rvalid),       32'h0);
    chk({tag, "_busy"},   32'(bus.busy),         32'h0);
    chk({tag, "_rd_en"},  32'(bus.gpio_rd_en),   32'h0);
    chk({tag, "_wr_en"},  32'(bus.gpio_wr_en),   32'h0);
  endtask

  logic [1:0] exp_gnt [8];

  initial begin
    checks   = 0;
    failures = 0;
    exp_gnt  = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};

    // Reset with all masters requesting
    reset         = 1'b1;
    bus.req       = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = 4'b1101;
    bus.req_wdata = 64'h0000_00BB_0000_00AA;
    tick();
    tick();
    chk_quiet("rst");
    chk("rst_rdata",   bus.rdata,              32'h0);
    chk("rst_addr",    32'(bus.gpio_addr),     32'h0);
    chk("rst_data_in", bus.gpio_data_in,       32'h0);
    reset   = 1'b0;
    bus.req = 2'b00;
    tick();
    chk("post_rst_gnt1", 32'(bus.gnt), 32'h0);
    tick();
    chk("post_rst_gnt2", 32'(bus.gnt), 32'h0);

    // Single write by m0
    bus.req               = 2'b01;
    bus.req_we            = 2'b01;
    bus.req_addr[1:0]     = 2'd1;
    bus.req_wdata[31:0]   = 32'h0003_FFFF;
    tick();
    chk("wr_gnt",     32'(bus.gnt),        32'h1);
    chk("wr_wr_en",   32'(bus.gpio_wr_en), 32'h1);
    chk("wr_rd_en",   32'(bus.gpio_rd_en), 32'h0);
    chk("wr_addr",    32'(bus.gpio_addr),  32'h1);
    chk("wr_data_in", bus.gpio_data_in,    32'h0003_FFFF);
    chk("wr_busy",    32'(bus.busy),       32'h1);
    bus.req = 2'b00;
    tick();
    chk_quiet("wr_done");

    // Single read by m1 from register 0
    bus.req             = 2'b10;
    bus.req_we          = 2'b00;
    bus.req_addr[3:2]   = 2'd0;
    tick();
    chk("rd_gnt",   32'(bus.gnt),        32'h2);
    chk("rd_rd_en", 32'(bus.gpio_rd_en), 32'h1);
    chk("rd_wr_en", 32'(bus.gpio_wr_en), 32'h0);
    chk("rd_addr",  32'(bus.gpio_addr),  32'h0);
    bus.req = 2'b00;
    tick();
    chk("rd_wait_busy",   32'(bus.busy),   32'h1);
    chk("rd_wait_rvalid", 32'(bus.rvalid), 32'h0);
    chk("rd_wait_rd_en",  32'(bus.gpio_rd_en), 32'h0);
    tick();
    chk("rd_resp_rvalid", 32'(bus.rvalid), 32'h2);
    chk("rd_resp_rdata",  bus.rdata,       32'h5);
    chk("rd_resp_busy",   32'(bus.busy),   32'h1);
    tick();
    chk_quiet("rd_done");
    chk("rd_hold_rdata", bus.rdata, 32'h5);

    // Contention from reset: both masters write continuously
    reset = 1'b1;
    tick();
    reset         = 1'b0;
    bus.req       = 2'b11;
    bus.req_we    = 2'b11;
    bus.req_addr  = 4'b1110;
    bus.req_wdata = 64'h0000_000B_0000_000A;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("cont_gnt%0d", i), 32'(bus.gnt), 32'(exp_gnt[i]));
      if (exp_gnt[i] == 2'b01) chk($sformatf("cont_addr%0d", i), 32'(bus.gpio_addr), 32'h2);
      if (exp_gnt[i] == 2'b10) chk($sformatf("cont_addr%0d", i), 32'(bus.gpio_addr), 32'h3);
      if (i == 6) bus.req = 2'b00;
    end

    // Reset during RDWAIT aborts the read (m0 reads register 2 = 0xA)
    bus.req           = 2'b01;
    bus.req_we        = 2'b00;
    bus.req_addr[1:0] = 2'd2;
    tick();
    chk("abort_gnt",   32'(bus.gnt),        32'h1);
    chk("abort_rd_en", 32'(bus.gpio_rd_en), 32'h1);
    bus.req = 2'b00;
    tick();
    chk("abort_wait_busy", 32'(bus.busy), 32'h1);
    reset = 1'b1;
    tick();
    chk_quiet("abort_rst");
    chk("abort_rdata", bus.rdata, 32'h0);
    reset = 1'b0;
    tick();
    chk_quiet("abort_post1");
    tick();
    chk_quiet("abort_post2");

    // Back-to-back writes by m0 with req held; fields change while busy
    bus.req             = 2'b01;
    bus.req_we          = 2'b01;
    bus.req_addr[1:0]   = 2'd1;
    bus.req_wdata[31:0] = 32'h100;
    tick();
    chk("b2b_wr0",   32'(bus.gpio_wr_en), 32'h1);
    chk("b2b_data0", bus.gpio_data_in,    32'h100);
    chk("b2b_gnt0",  32'(bus.gnt),        32'h1);
    bus.req_wdata[31:0] = 32'h200;
    tick();
    chk("b2b_gap0",  32'(bus.gpio_wr_en), 32'h0);
    chk("b2b_gap0d", bus.gpio_data_in,    32'h100);
    tick();
    chk("b2b_wr1",   32'(bus.gpio_wr_en), 32'h1);
    chk("b2b_data1", bus.gpio_data_in,    32'h200);
    chk("b2b_gnt1",  32'(bus.gnt),        32'h1);
    bus.req_wdata[31:0] = 32'h300;
    bus.req_addr[1:0]   = 2'd3;
    tick();
    chk("b2b_gap1",  32'(bus.gpio_wr_en), 32'h0);
    tick();
    chk("b2b_wr2",   32'(bus.gpio_wr_en), 32'h1);
    chk("b2b_data2", bus.gpio_data_in,    32'h300);
    chk("b2b_addr2", 32'(bus.gpio_addr),  32'h3);
    bus.req = 2'b00;
    tick();
    chk_quiet("b2b_done");
    chk("b2b_reg3", gpio_regs[3], 32'h300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
